mul_err_sweep: RTL
==================

MUL_ERR_SWEEP -- requirements
Module: mul_err_sweep

Interface
REQ-001 Parameter ET, default 2: maximum tolerated absolute error; a vector fails when its error exceeds ET.
REQ-002 Parameter OPW, default 2: operand width; product width is 2*OPW and vector count is 2^(2*OPW).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a full exhaustive sweep.
REQ-006 dut_in  output  2*OPW  stimulus to the downstream combinational multiplier, driven straight from the vector register; [OPW-1:0] = operand A, [2*OPW-1:OPW] = operand B (bit i maps to DUT in<i>).
REQ-007 dut_out  input  2*OPW  product returned by the multiplier; bit i = DUT out<i>, LSB first.
REQ-008 busy  output  1  high while the sweep is running.
REQ-009 done  output  1  one-cycle pulse when the sweep completes.
REQ-010 pass  output  1  high when err_count == 0; valid from done onward.
REQ-011 max_err  output  2*OPW  largest |dut_out - A*B| seen in the sweep.
REQ-012 err_count  output  2*OPW+1  number of vectors with error > ET.
REQ-013 err_sum  output  2*OPW+4  sum of |error| over all vectors, for mean-error computation.
REQ-014 first_fail  output  2*OPW  vector index of the first failing vector; 0 when there are none.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 IDLE: start=1 SHALL clear all result registers, set the vector register to 0 and enter RUN on the next edge.
REQ-017 RUN: each cycle SHALL evaluate exactly one vector; the DUT is combinational, so dut_out is sampled in the same cycle the vector is driven.
REQ-018 RUN: the vector register SHALL increment by 1 per cycle.
REQ-019 RUN: on the cycle the vector is all-ones, that vector SHALL be evaluated and the FSM SHALL enter DONE; the register wraps to 0.
REQ-020 A sweep SHALL last 2^(2*OPW) cycles (16 at defaults).
REQ-021 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-022 busy SHALL equal 1 in RUN only.
REQ-023 The error SHALL be computed as an unsigned absolute difference at product width with no overflow.
REQ-024 max_err SHALL update only on a strictly larger error.
REQ-025 err_count and err_sum SHALL saturate at their maximum values, which are unreachable at defaults.
REQ-026 first_fail SHALL be captured only on the first failing vector; a sticky flag blocks later overwrites.
REQ-027 start SHALL be ignored in RUN and in DONE.
REQ-028 start held high through IDLE SHALL launch back-to-back sweeps, with one IDLE cycle between them.
REQ-029 Results SHALL hold stable in IDLE until the next accepted start.
REQ-030 dut_in SHALL hold its last value (0 after wrap) outside RUN.

Reset
REQ-031 rst_n low SHALL asynchronously force: IDLE; vector register 0; busy=0, done=0, pass=0; max_err=0, err_count=0, err_sum=0, first_fail=0; sticky flag cleared.
REQ-032 Reset during RUN SHALL abort the sweep with no done pulse; a new start is required afterwards.
REQ-033 Reset release SHALL be sampled on clk, with the first start accepted on the first edge after release.

Structure
REQ-034 Package mul_eval_pkg SHALL hold the FSM state enum, the default ET and OPW, and the derived widths (PW = 2*OPW, NVEC = 2^PW).
REQ-035 Sub-module mul_exact SHALL compute the reference product A*B, OPW x OPW -> 2*OPW, combinationally.
REQ-036 mul_err_sweep SHALL contain only the FSM, the vector counter, the error datapath and the result registers.

Verification
REQ-037 Exact multiplier model on dut_out, start pulsed -> busy for 16 cycles, done on cycle 17, pass=1, max_err=0, err_count=0, err_sum=0, first_fail=0.
REQ-038 dut_out stuck at 0 -> max_err=9, err_count=6, err_sum=36, first_fail=7 (A=3, B=1), pass=0.
REQ-039 Exact model with +2 added only at vector 9 -> pass=1, max_err=2, err_sum=2, err_count=0.
REQ-040 Exact model with +3 added only at vector 9 -> pass=0, err_count=1, first_fail=9.
REQ-041 rst_n low at RUN cycle 8 -> immediate IDLE, all outputs 0, no done pulse; a fresh start gives results identical to REQ-037.
REQ-042 start held high continuously -> done every 18 cycles; start pulsed mid-RUN -> no effect on the running sweep.

Source files
------------

// File: rtl/mul_eval_pkg.sv
// Shared types and default sizing for the exhaustive multiplier error sweep.
package mul_eval_pkg;

    localparam int DEF_ET   = 2;
    localparam int DEF_OPW  = 2;
    localparam int PW       = 2 * DEF_OPW;
    localparam int NVEC     = 1 << PW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_exact.sv
// Golden reference multiplier: unsigned OPW x OPW -> 2*OPW product, combinational.
`default_nettype none

module mul_exact
    import mul_eval_pkg::*;
#(
    parameter int OPW = DEF_OPW
)(
    input  logic [OPW-1:0]   i_a,
    input  logic [OPW-1:0]   i_b,
    output logic [2*OPW-1:0] o_p
);

    assign o_p = (2*OPW)'(i_a) * (2*OPW)'(i_b);

endmodule

`default_nettype wire

// File: rtl/mul_err_sweep.sv
// Drives every operand pair into an external multiplier and accumulates error statistics.
`default_nettype none

module mul_err_sweep
    import mul_eval_pkg::*;
#(
    parameter int ET  = DEF_ET,
    parameter int OPW = DEF_OPW
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [2*OPW-1:0]     dut_in,
    input  logic [2*OPW-1:0]     dut_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*OPW-1:0]     max_err,
    output logic [2*OPW:0]       err_count,
    output logic [2*OPW+3:0]     err_sum,
    output logic [2*OPW-1:0]     first_fail
);

    localparam int c_PW = 2 * OPW;

    state_t              r_state;
    logic [c_PW-1:0]     r_vec;
    logic [c_PW-1:0]     r_max_err;
    logic [c_PW:0]       r_err_cnt;
    logic [c_PW+3:0]     r_err_sum;
    logic [c_PW-1:0]     r_first_fail;
    logic                r_sticky;
    logic                r_pass;

    logic [c_PW-1:0]     w_ref;
    logic [c_PW-1:0]     w_err;
    logic                w_fail;
    logic                w_last;
    logic                w_cnt_sat;
    logic [c_PW:0]       w_cnt_next;
    logic [c_PW+4:0]     w_sum_ext;

    mul_exact #(
        .OPW (OPW)
    ) u_ref (
        .i_a (r_vec[OPW-1:0]),
        .i_b (r_vec[c_PW-1:OPW]),
        .o_p (w_ref)
    );

    // Ordering the subtraction keeps the magnitude exact at product width.
    assign w_err      = (dut_out >= w_ref) ? (dut_out - w_ref) : (w_ref - dut_out);
    assign w_fail     = (32'(w_err) > ET);
    assign w_last     = &r_vec;
    assign w_cnt_sat  = &r_err_cnt;
    assign w_cnt_next = (w_fail && !w_cnt_sat) ? (r_err_cnt + (c_PW+1)'(1)) : r_err_cnt;
    assign w_sum_ext  = {1'b0, r_err_sum} + (c_PW+5)'(w_err);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_vec        <= '0;
            r_max_err    <= '0;
            r_err_cnt    <= '0;
            r_err_sum    <= '0;
            r_first_fail <= '0;
            r_sticky     <= 1'b0;
            r_pass       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state      <= ST_RUN;
                        r_vec        <= '0;
                        r_max_err    <= '0;
                        r_err_cnt    <= '0;
                        r_err_sum    <= '0;
                        r_first_fail <= '0;
                        r_sticky     <= 1'b0;
                        r_pass       <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_vec     <= r_vec + c_PW'(1);
                    r_err_cnt <= w_cnt_next;
                    r_err_sum <= w_sum_ext[c_PW+4] ? '1 : w_sum_ext[c_PW+3:0];
                    if (w_err > r_max_err) begin
                        r_max_err <= w_err;
                    end
                    if (w_fail && !r_sticky) begin
                        r_first_fail <= r_vec;
                        r_sticky     <= 1'b1;
                    end
                    // Verdict is formed with the last vector folded in so it is valid with done.
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_pass  <= (w_cnt_next == '0);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dut_in     = r_vec;
    assign busy       = (r_state == ST_RUN);
    assign done       = (r_state == ST_DONE);
    assign pass       = r_pass;
    assign max_err    = r_max_err;
    assign err_count  = r_err_cnt;
    assign err_sum    = r_err_sum;
    assign first_fail = r_first_fail;

endmodule

`default_nettype wire
